cipher_mode_engine: RTL and testbench
=====================================

Name: cipher_mode_engine

Overview:
Streaming block-cipher mode controller. It is the successor to the flat-bus ECB wrapper and adds runtime-selectable ECB, CBC-encrypt and CTR modes. Plaintext arrives one block per valid/ready beat, and ciphertext leaves the same way, so the block count is no longer bounded by port width. It instantiates gage_ingage_cipher and sits between the processor datapath and that core.

Parameters:
BLOCK_SIZE, 64, cipher block width in bits
KEY_SIZE, 64, key width in bits
CNT_W, 16, width of block-count and block-index fields

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin a message; sampled only in IDLE
mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved; latched on start
key  in  KEY_SIZE  cipher key; latched on start
iv  in  BLOCK_SIZE  CBC IV or CTR initial counter; latched on start
num_blocks  in  CNT_W  message length in blocks; latched on start
in_valid  in  1  plaintext beat valid
in_data  in  BLOCK_SIZE  plaintext block
in_ready  out  1  engine accepts plaintext
out_valid  out  1  ciphertext beat valid
out_data  out  BLOCK_SIZE  ciphertext block
out_ready  in  1  downstream accepts ciphertext
busy  out  1  high in any state other than IDLE
blk_idx  out  CNT_W  index of the block currently in flight
done  out  1  one-cycle pulse after the last beat is accepted
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high. It also drives the cipher core's reset.
- Reset values: all outputs 0 and state IDLE. Reset mid-message abandons the message with no done pulse; the chain register and counter clear.
- FSM states: IDLE, WAIT_IN, KICK, RUN, OUT, DONE.
- IDLE:
  - start with num_blocks==0 or an unsupported mode → err=1 for one cycle, stay IDLE.
  - Otherwise latch mode, key, iv, num_blocks; chain<=iv; blk_idx<=0; go to WAIT_IN.
- WAIT_IN:
  - in_ready=1. in_ready is high only in this state.
  - On in_valid&&in_ready: capture in_data into pt_reg and go to KICK.
- Cipher input, by mode:
  - ECB: pt_reg.
  - CBC: pt_reg^chain.
  - CTR: chain (the counter).
- KICK: assert cipher start for exactly one cycle, then go to RUN.
- RUN:
  - Wait for cipher done; core latency is variable and unbounded.
  - On done, set out_data by mode: ECB ct; CBC ct, with chain<=ct; CTR ct^pt_reg, with chain<=chain+1 modulo 2^BLOCK_SIZE (wraps all-ones→0).
  - Go to OUT.
- OUT:
  - out_valid=1. out_data is held stable until out_ready.
  - On out_valid&&out_ready: if blk_idx==num_blocks-1 go to DONE, else blk_idx<=blk_idx+1 and go to WAIT_IN.
- DONE: done=1 for one cycle, then IDLE. A start in the same cycle is ignored; start is only sampled in IDLE.
- start while busy is ignored: no err, no effect.
- Latched key, mode and iv are immune to input changes mid-message.
- Minimum latency per block: 1 cycle (accept) + 1 (KICK) + core latency + 1 (OUT).

Optional Feature:
CIPHER_MODE_CTR_EN
- Defined: mode 10 (CTR) is supported as described above.
- Undefined: the counter-increment and output-XOR logic are removed; mode 10 is treated as reserved, and start with mode 10 produces an err pulse.
- Mode 11 is always reserved and always produces err.

Decomposition:
- Shared package cipher_pkg holds:
  - the mode enum (MODE_ECB, MODE_CBC, MODE_CTR, MODE_RSVD);
  - the FSM state enum;
  - default BLOCK_SIZE/KEY_SIZE constants.
- The only sub-module is the existing gage_ingage_cipher. Mode pre-XOR and post-XOR stay inline; no further sub-module.

Test Plan:
- ECB, key 64'h0123456789ABCDEF, 3 blocks 64'h0/64'h1/64'h0 → blocks 0 and 2 give identical out_data equal to the golden model; done pulses once after the third beat.
- CBC, iv 64'hA5A5A5A5A5A5A5A5, 2 identical plaintext blocks 64'h1111111111111111 → ciphertexts differ and match the golden CBC model.
- CTR (macro defined), iv 64'hFFFFFFFFFFFFFFFF, 2 blocks → block 1 uses counter 64'h0 (wrap); out_data = E(ctr)^pt.
- Backpressure: hold out_ready low 5 cycles in OUT → out_valid stays 1, out_data unchanged, in_ready stays 0; the next block is accepted only after the handshake.
- Error cases:
  - start with num_blocks=0 → err pulse, busy stays 0.
  - mode 11 → err pulse.
  - CTR without the macro → err pulse.
- Reset asserted during RUN of block 1 of 4 → next cycle all outputs 0 and FSM in IDLE, no done. A fresh 1-block ECB message then completes correctly.

Source files
------------

// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared mode/state types and defaults for cipher_mode_engine (CTR support via CIPHER_MODE_CTR_EN)
package cipher_pkg;

    localparam int DEF_BLOCK_SIZE = 64;
    localparam int DEF_KEY_SIZE   = 64;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        MODE_ECB  = 2'b00,
        MODE_CBC  = 2'b01,
        MODE_CTR  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IN,
        ST_KICK,
        ST_RUN,
        ST_OUT,
        ST_DONE
    } state_e;

    function automatic logic mode_supported(input mode_e m);
`ifdef CIPHER_MODE_CTR_EN
        return (m != MODE_RSVD);
`else
        return (m == MODE_ECB) || (m == MODE_CBC);
`endif
    endfunction

endpackage

// File: rtl/gage_ingage_cipher.sv
// rtl/gage_ingage_cipher.sv - iterative block cipher core with data-dependent round count
module gage_ingage_cipher #(
    parameter int BLOCK_SIZE = 64,
    parameter int KEY_SIZE   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_SIZE-1:0]   key,
    input  logic [BLOCK_SIZE-1:0] data_in,
    output logic [BLOCK_SIZE-1:0] data_out,
    output logic                  done
);

    logic [BLOCK_SIZE-1:0] st_q, st_d;
    logic [BLOCK_SIZE-1:0] key_q, key_d;
    logic [3:0]            rnd_q, rnd_d;
    logic [3:0]            last_q, last_d;
    logic                  run_q, run_d;
    logic                  done_q, done_d;

    function automatic logic [BLOCK_SIZE-1:0] round_f(
        input logic [BLOCK_SIZE-1:0] s,
        input logic [BLOCK_SIZE-1:0] k,
        input logic [3:0]            r
    );
        logic [BLOCK_SIZE-1:0] t;
        t = s ^ k;
        return {t[BLOCK_SIZE-14:0], t[BLOCK_SIZE-1:BLOCK_SIZE-13]} + BLOCK_SIZE'(r);
    endfunction

    // Round count is 4..11, chosen by the low plaintext bits, so latency varies per block.
    always_comb begin
        st_d   = st_q;
        key_d  = key_q;
        rnd_d  = rnd_q;
        last_d = last_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            st_d   = data_in;
            key_d  = BLOCK_SIZE'(key);
            rnd_d  = 4'd0;
            last_d = 4'd3 + {1'b0, data_in[2:0]};
            run_d  = 1'b1;
        end else if (run_q) begin
            st_d  = round_f(st_q, key_q, rnd_q);
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == last_q) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= '0;
            key_q  <= '0;
            rnd_q  <= '0;
            last_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            key_q  <= key_d;
            rnd_q  <= rnd_d;
            last_q <= last_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign data_out = st_q;
    assign done     = done_q;

endmodule

// File: rtl/cipher_mode_engine.sv
// rtl/cipher_mode_engine.sv - streaming ECB/CBC/CTR mode controller; CTR built only with CIPHER_MODE_CTR_EN
module cipher_mode_engine
    import cipher_pkg::*;
#(
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int KEY_SIZE   = DEF_KEY_SIZE,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [KEY_SIZE-1:0]   key,
    input  logic [BLOCK_SIZE-1:0] iv,
    input  logic [CNT_W-1:0]      num_blocks,
    input  logic                  in_valid,
    input  logic [BLOCK_SIZE-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [BLOCK_SIZE-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_W-1:0]      blk_idx,
    output logic                  done,
    output logic                  err
);

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [KEY_SIZE-1:0]   key_q, key_d;
    logic [BLOCK_SIZE-1:0] chain_q, chain_d;
    logic [BLOCK_SIZE-1:0] pt_q, pt_d;
    logic [CNT_W-1:0]      num_q, num_d;
    logic [CNT_W-1:0]      blk_idx_q, blk_idx_d;
    logic [BLOCK_SIZE-1:0] out_data_q, out_data_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  core_start;
    logic                  core_done;
    logic [BLOCK_SIZE-1:0] core_in;
    logic [BLOCK_SIZE-1:0] core_ct;

    assign core_start = (state_q == ST_KICK);

    always_comb begin
        core_in = pt_q;
        case (mode_q)
            MODE_CBC: core_in = pt_q ^ chain_q;
`ifdef CIPHER_MODE_CTR_EN
            MODE_CTR: core_in = chain_q;
`endif
            default:  core_in = pt_q;
        endcase
    end

    gage_ingage_cipher #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .KEY_SIZE   (KEY_SIZE)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (core_start),
        .key      (key_q),
        .data_in  (core_in),
        .data_out (core_ct),
        .done     (core_done)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        key_d      = key_q;
        chain_d    = chain_q;
        pt_d       = pt_q;
        num_d      = num_q;
        blk_idx_d  = blk_idx_q;
        out_data_d = out_data_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_blocks == '0 || !mode_supported(mode_e'(mode))) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d    = mode_e'(mode);
                        key_d     = key;
                        chain_d   = iv;
                        num_d     = num_blocks;
                        blk_idx_d = '0;
                        state_d   = ST_WAIT_IN;
                    end
                end
            end
            ST_WAIT_IN: begin
                if (in_valid && in_ready_q) begin
                    pt_d    = in_data;
                    state_d = ST_KICK;
                end
            end
            ST_KICK: state_d = ST_RUN;
            ST_RUN: begin
                if (core_done) begin
                    out_data_d = core_ct;
                    case (mode_q)
                        MODE_CBC: chain_d = core_ct;
`ifdef CIPHER_MODE_CTR_EN
                        MODE_CTR: begin
                            out_data_d = core_ct ^ pt_q;
                            chain_d    = chain_q + BLOCK_SIZE'(1);
                        end
`endif
                        default: chain_d = chain_q;
                    endcase
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    if (blk_idx_q == num_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        blk_idx_d = blk_idx_q + CNT_W'(1);
                        state_d   = ST_WAIT_IN;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Handshake/status outputs are decoded from the next state so they are registered.
        in_ready_d  = (state_d == ST_WAIT_IN);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ECB;
            key_q       <= '0;
            chain_q     <= '0;
            pt_q        <= '0;
            num_q       <= '0;
            blk_idx_q   <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            key_q       <= key_d;
            chain_q     <= chain_d;
            pt_q        <= pt_d;
            num_q       <= num_d;
            blk_idx_q   <= blk_idx_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign blk_idx   = blk_idx_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cipher_mode_engine.sv
// tb/tb_cipher_mode_engine.sv - self-checking bench for cipher_mode_engine
module tb_cipher_mode_engine;

`ifdef CIPHER_MODE_CTR_EN
    localparam bit CTR_EN = 1'b1;
`else
    localparam bit CTR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]       mode;
        logic [63:0]      key;
        logic [63:0]      iv;
        logic [15:0]      n;
        logic [3:0][63:0] pt;
        logic [3:0][63:0] exp;
        logic             exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [63:0] key = '0;
    logic [63:0] iv = '0;
    logic [15:0] num_blocks = '0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [15:0] blk_idx;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cipher_mode_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .key        (key),
        .iv         (iv),
        .num_blocks (num_blocks),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .blk_idx    (blk_idx),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Core cipher: 4 + pt[2:0] rounds of s = rotl13(s ^ k) + round_number.
    function automatic logic [63:0] enc(input logic [63:0] k, input logic [63:0] p);
        logic [63:0] s;
        logic [63:0] t;
        int          n;
        s = p;
        n = 4 + int'(p[2:0]);
        for (int r = 0; r < n; r++) begin
            t = s ^ k;
            s = ((t << 13) | (t >> 51)) + 64'(r);
        end
        return s;
    endfunction

    function automatic logic [3:0][63:0] model(input vec_t v);
        logic [3:0][63:0] r;
        logic [63:0]      chain;
        r = '0;
        chain = v.iv;
        for (int i = 0; i < int'(v.n) && i < 4; i++) begin
            case (v.mode)
                2'd0: r[i] = enc(v.key, v.pt[i]);
                2'd1: begin
                    r[i] = enc(v.key, v.pt[i] ^ chain);
                    chain = r[i];
                end
                2'd2: r[i] = enc(v.key, v.iv + 64'(i)) ^ v.pt[i];
                default: r[i] = '0;
            endcase
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input logic [63:0] k, input logic [63:0] v_iv,
                                input logic [15:0] n, input logic [63:0] p0, input logic [63:0] p1,
                                input logic [63:0] p2, input logic [63:0] p3, input logic e);
        vec_t v;
        v.mode = m; v.key = k; v.iv = v_iv; v.n = n;
        v.pt[0] = p0; v.pt[1] = p1; v.pt[2] = p2; v.pt[3] = p3;
        v.exp_err = e;
        v.exp = '0;
        v.exp = model(v);
        return v;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic run_msg(input vec_t v, input bit stall, output logic [3:0][63:0] got);
        int          pi = 0;
        int          oi = 0;
        int          cyc = 0;
        int          dones = 0;
        bit          stalled = 1'b0;
        logic [63:0] held;
        got = '0;
        @(negedge clk);
        start = 1'b1; mode = v.mode; key = v.key; iv = v.iv; num_blocks = v.n;
        @(negedge clk);
        start = 1'b0;
        if (v.exp_err) begin
            chk("err_pulse", 64'(err), 64'd1);
            chk("err_busy", 64'(busy), 64'd0);
            @(negedge clk);
            chk("err_clear", 64'(err), 64'd0);
            chk("err_still_idle", 64'(busy), 64'd0);
            return;
        end
        chk("busy_after_start", 64'(busy), 64'd1);
        while (oi < int'(v.n) && cyc < 500) begin
            // Scramble the latched-on-start inputs and poke start: all must be ignored mid-message.
            mode = 2'($urandom); key = rnd64(); iv = rnd64(); num_blocks = 16'($urandom);
            start = ($urandom_range(0, 7) == 0);
            chk("err_while_busy", 64'(err), 64'd0);
            if (done) dones++;
            if (stall && !stalled && out_valid) begin
                stalled = 1'b1;
                in_valid = 1'b0;
                out_ready = 1'b0;
                held = out_data;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                    chk("stall_out_data", out_data, held);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
                continue;
            end
            in_valid = (pi < int'(v.n)) && ($urandom_range(0, 3) != 0);
            in_data = in_valid ? v.pt[pi] : rnd64();
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) pi++;
            if (out_valid && out_ready) begin
                got[oi] = out_data;
                chk($sformatf("out_data[%0d]", oi), out_data, v.exp[oi]);
                chk($sformatf("blk_idx[%0d]", oi), 64'(blk_idx), 64'(oi));
                oi++;
            end
            @(negedge clk);
            cyc++;
        end
        if (oi < int'(v.n)) begin
            checks++;
            failures++;
            $display("FAIL msg_timeout actual=%0d_blocks required=%0d_blocks", oi, v.n);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("no_early_done", 64'(dones), 64'd0);
        chk("out_valid_after_last", 64'(out_valid), 64'd0);
        // A valid start presented during DONE must be ignored.
        start = 1'b1; mode = 2'd0; num_blocks = 16'd1;
        @(negedge clk);
        start = 1'b0;
        chk("done_clears", 64'(done), 64'd0);
        chk("start_in_done_ignored", 64'(busy), 64'd0);
    endtask

    vec_t             vecs[7];
    logic [3:0][63:0] got_all[7];
    logic [3:0][63:0] g;
    logic [63:0]      p0, p1;
    vec_t             rv;
    int               cyc;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        p0 = 64'h1111111111111111;
        p1 = rnd64();
        vecs[0] = mk(2'd0, 64'h0123456789ABCDEF, '0, 16'd3, 64'h0, 64'h1, 64'h0, 64'h0, 1'b0);
        vecs[1] = mk(2'd1, rnd64(), 64'hA5A5A5A5A5A5A5A5, 16'd2, p0, p0, 64'h0, 64'h0, 1'b0);
        vecs[2] = mk(2'd0, rnd64(), rnd64(), 16'd4, rnd64(), rnd64(), rnd64(), rnd64(), 1'b0);
        vecs[3] = mk(2'd1, rnd64(), rnd64(), 16'd4, rnd64(), rnd64(), rnd64(), rnd64(), 1'b0);
        vecs[4] = mk(2'd2, rnd64(), 64'hFFFFFFFFFFFFFFFF, 16'd2, rnd64(), p1, 64'h0, 64'h0, !CTR_EN);
        vecs[5] = mk(2'd3, rnd64(), rnd64(), 16'd2, rnd64(), rnd64(), 64'h0, 64'h0, 1'b1);
        vecs[6] = mk(2'd0, rnd64(), rnd64(), 16'd0, rnd64(), rnd64(), 64'h0, 64'h0, 1'b1);

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_blk_idx", 64'(blk_idx), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_msg(vecs[i], (i == 2), got_all[i]);
        end
        chk("ecb_repeat_equal", got_all[0][2], got_all[0][0]);
        chk("cbc_blocks_differ", 64'(got_all[1][0] != got_all[1][1]), 64'd1);
`ifdef CIPHER_MODE_CTR_EN
        chk("ctr_wrap", got_all[4][1], enc(vecs[4].key, 64'h0) ^ p1);
`endif

        // Reset while block 1 of 4 is inside the core.
        rv = mk(2'd0, rnd64(), '0, 16'd4, rnd64(), rnd64(), rnd64(), rnd64(), 1'b0);
        @(negedge clk);
        start = 1'b1; mode = rv.mode; key = rv.key; iv = rv.iv; num_blocks = rv.n;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = rv.pt[0]; out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && out_ready) && cyc < 100) begin
            if (in_ready) in_data = rv.pt[0];
            @(negedge clk);
            cyc++;
        end
        chk("rst_seq_blk0", out_data, rv.exp[0]);
        in_data = rv.pt[1];
        @(negedge clk);
        chk("rst_seq_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_blk_idx", 64'(blk_idx), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        repeat (12) begin
            @(negedge clk);
            chk("midrst_no_done", 64'(done), 64'd0);
        end
        rv = mk(2'd0, rnd64(), '0, 16'd1, rnd64(), 64'h0, 64'h0, 64'h0, 1'b0);
        run_msg(rv, 1'b0, g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
